// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CHUNK = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of ripple slices (and pipeline ranks); never less than one.
    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned chunk);
        int unsigned n;
        n = width / chunk;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its MSB.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK - 1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, carry registered between
// stages, valid/ready on both sides with a single global advance enable.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // x holds finished sum chunks below the current slice and untouched A chunks above it.
    logic [WIDTH-1:0] x_in  [STAGES];
    logic [WIDTH-1:0] y_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic [WIDTH-1:0] x_nxt [STAGES];

    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             ovf_q;

    logic [CHUNK-1:0] s_chunk   [STAGES];
    logic             co_chunk  [STAGES];
    logic             msb_chunk [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign b_eff = (sub == OP_SUB) ? ~b : b;
    assign c0    = (sub == OP_SUB) ? ~cin : cin;

    always_comb begin
        x_in[0] = a;
        y_in[0] = b_eff;
        c_in[0] = c0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            x_in[k] = x_q[k - 1];
            y_in[k] = y_q[k - 1];
            c_in[k] = c_q[k - 1];
            v_in[k] = v_q[k - 1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a    (x_in[g][g*CHUNK +: CHUNK]),
            .b    (y_in[g][g*CHUNK +: CHUNK]),
            .cin  (c_in[g]),
            .sum  (s_chunk[g]),
            .cout (co_chunk[g]),
            .c_msb(msb_chunk[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            x_nxt[k]                   = x_in[k];
            x_nxt[k][k*CHUNK +: CHUNK] = s_chunk[k];
        end
    end

    // Data only loads behind a valid slot, so bubbles leave the last result on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                x_q[k] <= '0;
                y_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    x_q[k] <= x_nxt[k];
                    y_q[k] <= y_in[k];
                    c_q[k] <= co_chunk[k];
                end
            end
            if (v_in[STAGES - 1]) begin
                ovf_q <= co_chunk[STAGES - 1] ^ msb_chunk[STAGES - 1];
            end
        end
    end

    assign out_valid = v_q[STAGES - 1];
    assign sum       = x_q[STAGES - 1];
    assign cout      = c_q[STAGES - 1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, CHUNK=8, latency 4).
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned C   = 8;
    localparam int          LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    pipelined_adder #(
        .WIDTH(W),
        .CHUNK(C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Single op through an otherwise idle pipe; starts and ends just after a rising edge.
    task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input logic vcin, input logic vsub, input logic [31:0] es,
                          input logic eco, input logic eov);
        int lat;
        a = va; b = vb; cin = vcin; sub = vsub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_sum"}, 64'(sum), 64'(es));
        check({name, "_cout"}, 64'(cout), 64'(eco));
        check({name, "_ovf"}, 64'(ovf), 64'(eov));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, recv, stale;
        logic        held_v;
        logic [31:0] held;
        logic [31:0] bub_exp[4];

        vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD, 32'h2345_6789, 1'b0, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, OP_SUB, 32'h0000_0006, 1'b1, 1'b0};
        vecs[8]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, OP_ADD, 32'h0100_0100, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, OP_SUB, 32'h0000_0000, 1'b1, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, OP_ADD, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[11] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, OP_ADD, 32'h0001_0001, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = OP_ADD;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // Back-pressure: 8 ops a=b=i, consumer stalls in cycles 5..9
        sent = 0; recv = 0; held_v = 1'b0; held = '0;
        cin = 1'b0; sub = OP_ADD;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (sent < 8);
            a = 32'(sent); b = 32'(sent);
            @(negedge clk);
            if (held_v) check("bp_hold", 64'(sum), 64'(held));
            if (out_valid && !out_ready) begin
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                held_v = 1'b1;
                held   = sum;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (recv < 8) check($sformatf("bp_sum%0d", recv), 64'(sum), 64'(2 * recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_sent", 64'(sent), 64'd8);
        check("bp_recv", 64'(recv), 64'd8);

        // Bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 four cycles later
        bub_exp[0] = 32'h0000_0103; bub_exp[1] = 32'h0000_0103;
        bub_exp[2] = 32'h0000_0305; bub_exp[3] = 32'h0000_0305;
        for (int cyc = 0; cyc < 9; cyc++) begin
            in_valid = (cyc < 4) && (cyc % 2 == 0);
            a = 32'h100 * 32'(cyc + 1);
            b = 32'(cyc + 3);
            @(negedge clk);
            if (cyc < 4) begin
                check($sformatf("bub_idle%0d", cyc), 64'(out_valid), 64'd0);
            end else if (cyc < 8) begin
                check($sformatf("bub_valid%0d", cyc), 64'(out_valid),
                      64'((cyc - 4) % 2 == 0));
                check($sformatf("bub_sum%0d", cyc), 64'(sum), 64'(bub_exp[cyc - 4]));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Reset with a result at the output and three ops behind it
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = 1'b1;
            a = 32'(cyc + 1); b = 32'd10;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rmid_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_out_valid", 64'(out_valid), 64'd0);
        check("rmid_sum", 64'(sum), 64'd0);
        check("rmid_cout", 64'(cout), 64'd0);
        check("rmid_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stale = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        check("rmid_stale", 64'(stale), 64'd0);
        run_op("rmid_new", 32'h0000_1234, 32'h0000_4321, 1'b0, OP_ADD,
               32'h0000_5555, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the 4-bit combinational ripple adder.
- Splits a WIDTH-bit operation into CHUNK-bit ripple slices, one slice per pipeline stage, with carry registered between stages.
- Has valid/ready handshakes on both sides, so it sits between operand producers and a result consumer in datapaths that need throughput of one op/cycle at a higher clock rate.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage; STAGES = WIDTH/CHUNK, at least 1.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and controls valid this cycle
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- sub  input  1  1 = A - B (B inverted, carry-in = ~cin); 0 = A + B + cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits, out_valid, sum, cout and ovf go to 0 immediately. in_ready is 1 once the unit is out of reset.
- Reset mid-operation: all in-flight ops are discarded; no partial result appears.
- Accept rule: an op is accepted when in_valid && in_ready.
- Stage 0 captures:
  - A;
  - B' = sub ? ~b : b;
  - c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1):
  - adds chunk k of A and chunk k of B' plus the registered carry, using a CHUNK-bit ripple adder;
  - registers the sum chunk and the carry-out;
  - forwards the not-yet-used upper chunks;
  - retains the completed lower chunks.
- The last stage also registers ovf from its internal MSB carries.
- Latency: the result appears at the output registers exactly STAGES cycles after acceptance when there is no stall. Throughput is 1 op/cycle.
- Advance enable: adv = !out_valid || out_ready.
  - When adv = 1, every stage shifts forward one position, including bubbles (valid = 0).
  - When adv = 0, all stages and outputs hold.
- in_ready = adv, combinationally. An op is never dropped or duplicated.
- sum, cout and ovf are stable while out_valid && !out_ready.
- Bubbles: invalid slots propagate with valid = 0. Data in invalid slots is don't-care, but the outputs hold their last valid values.
- Simultaneous out_ready and in_valid at a full pipeline: the output is consumed and the new op is accepted in the same cycle.
- Arithmetic is modulo 2^WIDTH; cout carries the 2^WIDTH bit.
- STAGES = 1 degenerates to a single registered WIDTH-bit add.

Decomposition:
- Shared package adder_pkg:
  - default WIDTH and CHUNK constants;
  - localparam function for STAGES;
  - op-code constants OP_ADD = 0 and OP_SUB = 1.
- One sub-module, adder_chunk: combinational CHUNK-bit ripple slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into the MSB, used for ovf).
  - Instantiated STAGES times in a generate loop.

Test Plan (WIDTH=32, CHUNK=8, latency 4):
- Add with carry propagation: a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000_0100, cout=0, ovf=0.
- Full-width ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, ovf=1, cout=0.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-pressure: stream 8 back-to-back ops (a=i, b=i) with out_ready low for cycles 5-9 -> in_ready low while stalled, sum held stable, all 8 results 2i delivered in order with none lost or repeated.
- Bubbles: in_valid pattern 1,0,1,0 -> out_valid pattern 1,0,1,0 beginning 4 cycles later, with results matching.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 and sum=0 immediately; after release no stale result appears, and a new op completes in 4 cycles.
